// File: rtl/axi4_lite_manager.sv
// Single-outstanding AXI4-Lite manager: turns a simple request/response port into AW/W/B or AR/R traffic.
// Optional macro AXI4_LITE_MANAGER_RESP_CHECK_EN reports non-OKAY bresp/rresp on resp_err.
module axi4_lite_manager #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [2:0]              awprot,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [2:0]              arprot,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);

  // state        | meaning
  // IDLE         | waiting for a request, req_ready high
  // WR_ADDR_DATA | AW and W in flight, each retired independently
  // WR_RESP      | waiting for B
  // RD_ADDR      | AR in flight
  // RD_DATA      | waiting for R
  // RESP         | presenting the response to the requester
  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] WR_ADDR_DATA = 3'd1;
  localparam logic [2:0] WR_RESP      = 3'd2;
  localparam logic [2:0] RD_ADDR      = 3'd3;
  localparam logic [2:0] RD_DATA      = 3'd4;
  localparam logic [2:0] RESP         = 3'd5;

  logic [2:0]              state_q, state_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    aw_done, w_done;

  // A channel is done once its valid has dropped or it handshakes this cycle.
  assign aw_done = !awvalid_q || awready;
  assign w_done  = !wvalid_q || wready;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_write) begin
            state_d   = WR_ADDR_DATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = req_addr;
            wdata_d   = req_wdata;
            wstrb_d   = req_wstrb;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
            araddr_d  = req_addr;
          end
        end
      end
      WR_ADDR_DATA: begin
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done)    state_d   = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid) begin
          state_d = RESP;
          rdata_d = '0;
        end
      end
      RD_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          rdata_d = rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef AXI4_LITE_MANAGER_RESP_CHECK_EN
  logic err_q;

  always_ff @(posedge aclk) begin
    if (areset)                             err_q <= 1'b0;
    else if (state_q == WR_RESP && bvalid)  err_q <= (bresp != 2'b00);
    else if (state_q == RD_DATA && rvalid)  err_q <= (rresp != 2'b00);
  end

  assign resp_err = err_q;
`else
  logic unused_resp;
  assign unused_resp = ^{bresp, rresp};
  assign resp_err    = 1'b0;
`endif

  assign req_ready  = (state_q == IDLE);
  assign bready     = (state_q == WR_RESP);
  assign rready     = (state_q == RD_DATA);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign awvalid    = awvalid_q;
  assign wvalid     = wvalid_q;
  assign arvalid    = arvalid_q;
  assign awaddr     = awaddr_q;
  assign araddr     = araddr_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign awprot     = 3'b000;
  assign arprot     = 3'b000;

endmodule

// File: tb/tb_axi4_lite_manager.sv
// Directed bench for axi4_lite_manager with a small configurable-latency AXI4-Lite memory.
module tb_axi4_lite_manager;

`ifdef AXI4_LITE_MANAGER_RESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        areset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_cmp = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  axi4_lite_manager #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awprot(awprot),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arprot(arprot),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  // Subordinate memory model with programmable AW/W stall and a switch to withhold R.
  logic [31:0] mem [0:15];
  int          aw_delay = 0, w_delay = 0, aw_cnt = 0, w_cnt = 0;
  logic        r_block = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [31:0] aw_a, w_d, r_data_q;
  logic [3:0]  w_s;
  logic        aw_hs, w_hs, wr_fire;
  logic [31:0] aw_a_n, w_d_n;
  logic [3:0]  w_s_n;

  assign awready = awvalid && (aw_cnt >= aw_delay);
  assign wready  = wvalid && (w_cnt >= w_delay);
  assign arready = arvalid;
  assign bvalid  = b_pend;
  assign bresp   = bresp_cfg;
  assign rvalid  = r_pend && !r_block;
  assign rdata   = r_data_q;
  assign rresp   = rresp_cfg;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign aw_a_n  = aw_hs ? awaddr : aw_a;
  assign w_d_n   = w_hs ? wdata : w_d;
  assign w_s_n   = w_hs ? wstrb : w_s;
  assign wr_fire = !b_pend && (aw_got || aw_hs) && (w_got || w_hs);

  always @(posedge aclk) begin
    if (areset) begin
      aw_cnt <= 0; w_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      aw_a <= '0; w_d <= '0; w_s <= '0; r_data_q <= '0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (aw_hs) begin aw_got <= 1'b1; aw_a <= awaddr; end
      if (w_hs)  begin w_got <= 1'b1; w_d <= wdata; w_s <= wstrb; end
      if (wr_fire) begin
        b_pend <= 1'b1;
        for (int i = 0; i < 4; i++)
          if (w_s_n[i]) mem[aw_a_n[5:2]][8*i +: 8] <= w_d_n[8*i +: 8];
      end
      if (bvalid && bready) begin
        b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (arvalid && arready) begin
        r_pend   <= 1'b1;
        r_data_q <= mem[araddr[5:2]];
      end
      if (rvalid && rready) r_pend <= 1'b0;
    end
  end

  task automatic tick;
    @(negedge aclk);
  endtask

  // Present a request for one cycle; returns at the negedge of cycle 1.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL issue_req_ready: got %b want 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    areset = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({awvalid, wvalid, arvalid, bready, rready, resp_valid, resp_err, req_ready} !== 8'b0000_0001) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 00000001",
               {awvalid, wvalid, arvalid, bready, rready, resp_valid, resp_err, req_ready});
    end
    n_cmp++;
    if ({resp_rdata, awaddr, araddr, wdata, wstrb, awprot, arprot} !== '0) begin
      n_err++;
      $display("FAIL reset_data: rdata %h awaddr %h araddr %h wdata %h wstrb %h want all 0",
               resp_rdata, awaddr, araddr, wdata, wstrb);
    end
    areset = 1'b0;
    tick();
  endtask

  task automatic test_write_basic;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    n_cmp++;
    if ({awvalid, wvalid, bready, resp_valid, awaddr, wdata, wstrb} !== {4'b1100, 32'h10, 32'hDEADBEEF, 4'hF}) begin
      n_err++;
      $display("FAIL wr_cycle1: aw %b w %b b %b rv %b awaddr %h wdata %h want 1100 10 deadbeef",
               awvalid, wvalid, bready, resp_valid, awaddr, wdata);
    end
    tick();
    n_cmp++;
    if ({awvalid, wvalid, bready, resp_valid} !== 4'b0010) begin
      n_err++;
      $display("FAIL wr_cycle2: got %b want 0010", {awvalid, wvalid, bready, resp_valid});
    end
    tick();
    n_cmp++;
    if ({bready, resp_valid, resp_err, resp_rdata} !== {3'b010, 32'h0}) begin
      n_err++;
      $display("FAIL wr_cycle3: b %b rv %b err %b rdata %h want 0 1 0 0",
               bready, resp_valid, resp_err, resp_rdata);
    end
    tick();
    n_cmp++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL wr_idle: got %b want 10", {req_ready, resp_valid});
    end
  endtask

  task automatic test_read_basic;
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    n_cmp++;
    if ({arvalid, rready, resp_valid, awvalid, araddr} !== {4'b1000, 32'h10}) begin
      n_err++;
      $display("FAIL rd_cycle1: ar %b r %b rv %b aw %b araddr %h want 1000 10",
               arvalid, rready, resp_valid, awvalid, araddr);
    end
    tick();
    n_cmp++;
    if ({arvalid, rready, resp_valid} !== 3'b010) begin
      n_err++;
      $display("FAIL rd_cycle2: got %b want 010", {arvalid, rready, resp_valid});
    end
    tick();
    n_cmp++;
    if ({rready, resp_valid, resp_err, resp_rdata} !== {3'b010, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL rd_cycle3: r %b rv %b err %b rdata %h want 0 1 0 deadbeef",
               rready, resp_valid, resp_err, resp_rdata);
    end
    tick();
  endtask

  // AW and W stalled by independent amounts; expectations follow from the stall counts.
  task automatic test_delayed(input int aw_d, input int w_d_in, input logic [31:0] a,
                              input logic [31:0] d);
    int aw_cyc = 0, w_cyc = 0, b_first = 0, b_cyc = 0, rv_cyc = 0, rv_first = 0, bad = 0;
    int mx;
    mx = (aw_d > w_d_in) ? aw_d : w_d_in;
    aw_delay = aw_d; w_delay = w_d_in;
    issue(1'b1, a, d, 4'hF);
    for (int c = 1; c <= 12; c++) begin
      if (awvalid) begin aw_cyc++; if (awaddr !== a) bad++; end
      if (wvalid)  begin w_cyc++;  if (wdata !== d) bad++; end
      if (bready) begin
        b_cyc++;
        if (b_first == 0) b_first = c;
        if (awvalid || wvalid) bad++;
      end
      if (resp_valid) begin rv_cyc++; if (rv_first == 0) rv_first = c; end
      tick();
    end
    n_cmp++;
    if (aw_cyc !== aw_d + 1 || w_cyc !== w_d_in + 1) begin
      n_err++;
      $display("FAIL dly_valid_len(%0d,%0d): aw %0d w %0d want %0d %0d",
               aw_d, w_d_in, aw_cyc, w_cyc, aw_d + 1, w_d_in + 1);
    end
    n_cmp++;
    if (b_first !== mx + 2 || b_cyc !== 1) begin
      n_err++;
      $display("FAIL dly_bready(%0d,%0d): first %0d count %0d want %0d 1",
               aw_d, w_d_in, b_first, b_cyc, mx + 2);
    end
    n_cmp++;
    if (rv_first !== mx + 3 || rv_cyc !== 1 || bad !== 0) begin
      n_err++;
      $display("FAIL dly_resp(%0d,%0d): first %0d count %0d unstable %0d want %0d 1 0",
               aw_d, w_d_in, rv_first, rv_cyc, bad, mx + 3);
    end
    aw_delay = 0; w_delay = 0;
  endtask

  task automatic test_resp_stall;
    resp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    tick(); tick();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_wstrb = 4'hF;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({resp_valid, req_ready, awvalid, wvalid, resp_rdata} !== {4'b1000, 32'hDEADBEEF}) begin
        n_err++;
        $display("FAIL stall_%0d: rv %b req_ready %b aw %b w %b rdata %h want 1 0 0 0 deadbeef",
                 k, resp_valid, req_ready, awvalid, wvalid, resp_rdata);
      end
      tick();
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    n_cmp++;
    if ({req_ready, resp_valid, awvalid} !== 3'b100) begin
      n_err++;
      $display("FAIL stall_release: got %b want 100", {req_ready, resp_valid, awvalid});
    end
  endtask

  task automatic test_reset_mid;
    int rv_seen = 0;
    r_block = 1'b1;
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    tick(); tick();
    n_cmp++;
    if ({rready, arvalid, resp_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL mid_rd_data: got %b want 100", {rready, arvalid, resp_valid});
    end
    areset = 1'b1;
    tick();
    n_cmp++;
    if ({awvalid, wvalid, arvalid, bready, rready, resp_valid, req_ready, resp_rdata, araddr} !== {7'b0000001, 64'h0}) begin
      n_err++;
      $display("FAIL mid_reset: ctrl %b rdata %h araddr %h want 0000001 0 0",
               {awvalid, wvalid, arvalid, bready, rready, resp_valid, req_ready}, resp_rdata, araddr);
    end
    areset = 1'b0;
    r_block = 1'b0;
    tick();
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_after_reset: req_ready %b want 1", req_ready);
    end
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) rv_seen++;
      tick();
    end
    n_cmp++;
    if (rv_seen !== 0) begin
      n_err++;
      $display("FAIL mid_no_resp: resp_valid cycles %0d want 0", rv_seen);
    end
  endtask

  task automatic test_resp_err;
    bresp_cfg = 2'b10;
    issue(1'b1, 32'h14, 32'h1, 4'hF);
    tick(); tick();
    n_cmp++;
    if ({resp_valid, resp_err, resp_rdata} !== {1'b1, EXP_ERR, 32'h0}) begin
      n_err++;
      $display("FAIL bresp_err: rv %b err %b rdata %h want 1 %b 0", resp_valid, resp_err, resp_rdata, EXP_ERR);
    end
    tick();
    bresp_cfg = 2'b00;
    rresp_cfg = 2'b11;
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    tick(); tick();
    n_cmp++;
    if ({resp_valid, resp_err, resp_rdata} !== {1'b1, EXP_ERR, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL rresp_err: rv %b err %b rdata %h want 1 %b deadbeef", resp_valid, resp_err, resp_rdata, EXP_ERR);
    end
    tick();
    rresp_cfg = 2'b00;
    issue(1'b1, 32'h18, 32'h2, 4'hF);
    tick(); tick();
    n_cmp++;
    if ({resp_valid, resp_err} !== 2'b10) begin
      n_err++;
      $display("FAIL okay_clears_err: rv %b err %b want 1 0", resp_valid, resp_err);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    areset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    resp_ready = 1'b1;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_delayed(3, 0, 32'h20, 32'hA5A5_0001);
    test_delayed(0, 2, 32'h24, 32'hA5A5_0002);
    test_delayed(2, 2, 32'h28, 32'hA5A5_0003);
    test_resp_stall();
    test_reset_mid();
    test_resp_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
